// File: rtl/bool_sweep_pkg.sv
// rtl/bool_sweep_pkg.sv - shared state encoding and legal parameter ranges for bool_sweep
package bool_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int N_IN_MIN   = 1;
    localparam int N_IN_MAX   = 8;
    localparam int SETTLE_MIN = 0;
    localparam int SETTLE_MAX = 15;

endpackage

// File: rtl/bool_sweep_ctr.sv
// rtl/bool_sweep_ctr.sv - settle and vector counters for bool_sweep
module bool_sweep_ctr #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            run,
    output logic [N_IN-1:0] vec,
    output logic            sample_en,
    output logic            last_vec
);
    localparam logic [3:0]      SETTLE_V = 4'(SETTLE);
    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

    logic [3:0]      settle_q, settle_d;
    logic [N_IN-1:0] vec_q, vec_d;

    assign vec       = vec_q;
    assign sample_en = run && (settle_q == SETTLE_V);
    assign last_vec  = (vec_q == VEC_LAST);

    // The vector counter wraps to 0 after the final sample and stays there once run drops.
    always_comb begin
        settle_d = settle_q;
        vec_d    = vec_q;
        if (clear) begin
            settle_d = 4'd0;
            vec_d    = '0;
        end else if (run) begin
            if (settle_q == SETTLE_V) begin
                settle_d = 4'd0;
                vec_d    = vec_q + VEC_ONE;
            end else begin
                settle_d = settle_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_q <= 4'd0;
            vec_q    <= '0;
        end else begin
            settle_q <= settle_d;
            vec_q    <= vec_d;
        end
    end

endmodule

// File: rtl/bool_sweep.sv
// rtl/bool_sweep.sv - exhaustive truth-table sweep and compare engine for N-input boolean functions
module bool_sweep
    import bool_sweep_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        vec_out,
    input  logic                   f_in,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN:0]          mismatch_cnt,
    output logic [N_IN-1:0]        first_bad,
    output logic [(1<<N_IN)-1:0]   table_out
);
    localparam int            NVEC    = 1 << N_IN;
    localparam logic [N_IN:0] CNT_ONE = (N_IN+1)'(1);

    if (N_IN < N_IN_MIN || N_IN > N_IN_MAX || SETTLE < SETTLE_MIN || SETTLE > SETTLE_MAX) begin : g_bad_param
        $error("bool_sweep: N_IN or SETTLE outside legal range");
    end

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [N_IN:0]       mism_q, mism_d;
    logic [N_IN-1:0]     first_q, first_d;
    logic [NVEC-1:0]     table_q, table_d;
    logic [NVEC-1:0]     exp_q, exp_d;
    logic                ctr_clear, ctr_run;
    logic                sample_en, last_vec;
    logic [N_IN-1:0]     vec;

    bool_sweep_ctr #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (ctr_clear),
        .run       (ctr_run),
        .vec       (vec),
        .sample_en (sample_en),
        .last_vec  (last_vec)
    );

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        mism_d    = mism_q;
        first_d   = first_q;
        table_d   = table_q;
        exp_d     = exp_q;
        ctr_clear = 1'b0;
        ctr_run   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = DRIVE;
                    busy_d    = 1'b1;
                    exp_d     = expected;
                    table_d   = '0;
                    mism_d    = '0;
                    first_d   = '0;
                    pass_d    = 1'b0;
                    ctr_clear = 1'b1;
                end
            end
            DRIVE: begin
                ctr_run = 1'b1;
                if (sample_en) begin
                    table_d[vec] = f_in;
                    // A zero count before this sample marks the first mismatch of the sweep.
                    if (f_in != exp_q[vec]) begin
                        if (mism_q == '0) begin
                            first_d = vec;
                        end
                        mism_d = mism_q + CNT_ONE;
                    end
                    if (last_vec) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (mism_d == '0);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mism_q  <= '0;
            first_q <= '0;
            table_q <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            mism_q  <= mism_d;
            first_q <= first_d;
            table_q <= table_d;
            exp_q   <= exp_d;
        end
    end

    assign vec_out      = vec;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign mismatch_cnt = mism_q;
    assign first_bad    = first_q;
    assign table_out    = table_q;

endmodule

// File: tb/tb_bool_sweep.sv
// tb/tb_bool_sweep.sv - directed self-checking bench for bool_sweep
module tb_bool_sweep;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start4 = 1'b0;
    logic [15:0] expected4 = '0;
    logic [3:0]  vec4;
    logic        f4, busy4, done4, pass4;
    logic [4:0]  mism4;
    logic [3:0]  first4;
    logic [15:0] table4;

    logic        start5 = 1'b0;
    logic [31:0] expected5 = '0;
    logic [4:0]  vec5;
    logic        f5, busy5, done5, pass5;
    logic [5:0]  mism5;
    logic [4:0]  first5;
    logic [31:0] table5;

    int cmp = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign f4 = (vec4[3] ^ vec4[2]) & (~vec4[1] | vec4[0]);
    assign f5 = (vec5[4] & vec5[3]) | (~vec5[2] | (vec5[1] ^ vec5[0]));

    bool_sweep #(.N_IN(4), .SETTLE(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .expected(expected4), .vec_out(vec4),
        .f_in(f4), .busy(busy4), .done(done4), .pass(pass4), .mismatch_cnt(mism4),
        .first_bad(first4), .table_out(table4)
    );

    bool_sweep #(.N_IN(5), .SETTLE(0)) dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .expected(expected5), .vec_out(vec5),
        .f_in(f5), .busy(busy5), .done(done5), .pass(pass5), .mismatch_cnt(mism5),
        .first_bad(first5), .table_out(table5)
    );

    task automatic wait_done4(output int t);
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done4) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic wait_done5(output int t);
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done5) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic run4(input logic [15:0] e, output int lat);
        int t0, td;
        @(negedge clk);
        expected4 = e;
        start4 = 1'b1;
        @(negedge clk);
        t0 = cyc;
        start4 = 1'b0;
        cmp++; if (busy4 !== 1'b1) begin bad++; $display("FAIL run4_busy: got %b want 1", busy4); end
        cmp++; if (vec4 !== 4'd0) begin bad++; $display("FAIL run4_vec0: got %0d want 0", vec4); end
        @(negedge clk);
        @(negedge clk);
        cmp++; if (vec4 !== 4'd1) begin bad++; $display("FAIL run4_vec1: got %0d want 1", vec4); end
        wait_done4(td);
        lat = (td < 0) ? -1 : td - t0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp++; if (busy4 !== 1'b0 || done4 !== 1'b0 || pass4 !== 1'b0) begin bad++; $display("FAIL reset_flags4: got %b%b%b want 000", busy4, done4, pass4); end
        cmp++; if (vec4 !== 4'd0 || mism4 !== 5'd0 || first4 !== 4'd0) begin bad++; $display("FAIL reset_cnt4: got %h %h %h want 0 0 0", vec4, mism4, first4); end
        cmp++; if (table4 !== 16'h0) begin bad++; $display("FAIL reset_table4: got %h want 0000", table4); end
        cmp++; if (busy5 !== 1'b0 || done5 !== 1'b0 || table5 !== 32'h0) begin bad++; $display("FAIL reset_dut5: got %b %b %h want 0 0 0", busy5, done5, table5); end
        rst_n = 1'b1;
    endtask

    task automatic test_pass4;
        int lat;
        run4(16'h0BB0, lat);
        cmp++; if (lat !== 32) begin bad++; $display("FAIL pass4_latency: got %0d want 32", lat); end
        cmp++; if (table4 !== 16'h0BB0) begin bad++; $display("FAIL pass4_table: got %h want 0bb0", table4); end
        cmp++; if (pass4 !== 1'b1 || mism4 !== 5'd0 || first4 !== 4'd0) begin bad++; $display("FAIL pass4_result: got %b %0d %0d want 1 0 0", pass4, mism4, first4); end
        cmp++; if (busy4 !== 1'b0 || vec4 !== 4'd0) begin bad++; $display("FAIL pass4_idle: got %b %0d want 0 0", busy4, vec4); end
        @(negedge clk);
        cmp++; if (done4 !== 1'b0) begin bad++; $display("FAIL pass4_done_width: got %b want 0", done4); end
        repeat (3) @(negedge clk);
        cmp++; if (pass4 !== 1'b1 || table4 !== 16'h0BB0) begin bad++; $display("FAIL pass4_hold: got %b %h want 1 0bb0", pass4, table4); end
    endtask

    task automatic test_mismatch4;
        int lat;
        run4(16'h0BB1, lat);
        cmp++; if (pass4 !== 1'b0 || mism4 !== 5'd1 || first4 !== 4'd0) begin bad++; $display("FAIL mism4_bit0: got %b %0d %0d want 0 1 0", pass4, mism4, first4); end
        run4(16'h0B30, lat);
        cmp++; if (pass4 !== 1'b0 || mism4 !== 5'd1 || first4 !== 4'd7) begin bad++; $display("FAIL mism4_bit7: got %b %0d %0d want 0 1 7", pass4, mism4, first4); end
        cmp++; if (table4 !== 16'h0BB0) begin bad++; $display("FAIL mism4_table: got %h want 0bb0", table4); end
        run4(16'hF44F, lat);
        cmp++; if (mism4 !== 5'd16 || first4 !== 4'd0 || pass4 !== 1'b0) begin bad++; $display("FAIL mism4_all: got %0d %0d %b want 16 0 0", mism4, first4, pass4); end
    endtask

    task automatic test_n5;
        int t0, td;
        @(negedge clk);
        expected5 = 32'hFF6F6F6F;
        start5 = 1'b1;
        @(negedge clk);
        t0 = cyc;
        start5 = 1'b0;
        cmp++; if (busy5 !== 1'b1 || vec5 !== 5'd0) begin bad++; $display("FAIL n5_start: got %b %0d want 1 0", busy5, vec5); end
        @(negedge clk);
        cmp++; if (vec5 !== 5'd1) begin bad++; $display("FAIL n5_vec1: got %0d want 1", vec5); end
        wait_done5(td);
        cmp++; if (td < 0 || td - t0 !== 32) begin bad++; $display("FAIL n5_latency: got %0d want 32", (td < 0) ? -1 : td - t0); end
        cmp++; if (pass5 !== 1'b1 || mism5 !== 6'd0 || table5 !== 32'hFF6F6F6F) begin bad++; $display("FAIL n5_result: got %b %0d %h want 1 0 ff6f6f6f", pass5, mism5, table5); end
    endtask

    task automatic test_reset_mid;
        int lat;
        bit seen;
        @(negedge clk);
        expected4 = 16'hFFFF;
        start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        cmp++; if (busy4 !== 1'b0 || vec4 !== 4'd0) begin bad++; $display("FAIL rstmid_busy_vec: got %b %0d want 0 0", busy4, vec4); end
        cmp++; if (table4 !== 16'h0 || mism4 !== 5'd0 || pass4 !== 1'b0) begin bad++; $display("FAIL rstmid_results: got %h %0d %b want 0 0 0", table4, mism4, pass4); end
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done4) seen = 1'b1;
        end
        cmp++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_no_done: got %b want 0", seen); end
        run4(16'h0BB0, lat);
        cmp++; if (lat !== 32 || pass4 !== 1'b1 || table4 !== 16'h0BB0) begin bad++; $display("FAIL rstmid_restart: got %0d %b %h want 32 1 0bb0", lat, pass4, table4); end
    endtask

    task automatic test_back_to_back;
        int t0, td1, td2, td3;
        @(negedge clk);
        expected4 = 16'h0BB0;
        start4 = 1'b1;
        @(negedge clk);
        t0 = cyc;
        repeat (9) @(negedge clk);
        expected4 = 16'h0BB1;
        wait_done4(td1);
        cmp++; if (td1 < 0 || td1 - t0 !== 32) begin bad++; $display("FAIL b2b_first_latency: got %0d want 32", (td1 < 0) ? -1 : td1 - t0); end
        cmp++; if (pass4 !== 1'b1 || mism4 !== 5'd0) begin bad++; $display("FAIL b2b_first_result: got %b %0d want 1 0", pass4, mism4); end
        repeat (10) @(negedge clk);
        expected4 = 16'h0B30;
        wait_done4(td2);
        cmp++; if (td1 < 0 || td2 < 0 || td2 - td1 !== 34) begin bad++; $display("FAIL b2b_period2: got %0d want 34", td2 - td1); end
        cmp++; if (pass4 !== 1'b0 || mism4 !== 5'd1 || first4 !== 4'd0) begin bad++; $display("FAIL b2b_second_result: got %b %0d %0d want 0 1 0", pass4, mism4, first4); end
        wait_done4(td3);
        start4 = 1'b0;
        cmp++; if (td2 < 0 || td3 < 0 || td3 - td2 !== 34) begin bad++; $display("FAIL b2b_period3: got %0d want 34", td3 - td2); end
        cmp++; if (pass4 !== 1'b0 || mism4 !== 5'd1 || first4 !== 4'd7) begin bad++; $display("FAIL b2b_third_result: got %b %0d %0d want 0 1 7", pass4, mism4, first4); end
        @(negedge clk);
        cmp++; if (done4 !== 1'b0) begin bad++; $display("FAIL b2b_done_width: got %b want 0", done4); end
        repeat (3) @(negedge clk);
        cmp++; if (busy4 !== 1'b0) begin bad++; $display("FAIL b2b_stopped: got %b want 0", busy4); end
    endtask

    initial begin
        test_reset();
        test_pass4();
        test_mismatch4();
        test_n5();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
